// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encoding and
// the saturating next-state function used by the history table.
package bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam logic [1:0] BP_CNT_RST = BP_WNT;

    function automatic logic [1:0] bpNextCnt(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BP_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port (fetch) and one write port (execute).
module bp_bht
    import bp_pkg::*;
#(
    parameter int ENTRIES = 256,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rdIdx,
    output logic          rdTaken,
    input  logic          wrEn,
    input  logic [IW-1:0] wrIdx,
    input  logic          wrTaken
);

    logic [1:0] cnt [ENTRIES];

    // Read sees the pre-update value when rdIdx == wrIdx on the same cycle.
    assign rdTaken = cnt[rdIdx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= BP_CNT_RST;
        end else if (wrEn) begin
            cnt[wrIdx] <= bpNextCnt(cnt[wrIdx], wrTaken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit BHT, with EX-stage
// mispredict detection. Optional performance counters under BP_PERF_CNT_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int BHT_ENTRIES = 256,
    parameter int PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] PCF,
    output logic            PredTakenF,
    output logic [PC_W-1:0] PredTargetF,
    input  logic            UpdateE,
    input  logic [PC_W-1:0] PCE,
    input  logic            BrTakenE,
    input  logic [PC_W-1:0] BrTargetE,
    input  logic            PredTakenE,
    input  logic [PC_W-1:0] PredTargetE,
    output logic            MispredictE,
    output logic [PC_W-1:0] CorrectPCE,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     MissCnt
);

    localparam int IB    = $clog2(BTB_ENTRIES);
    localparam int HB    = $clog2(BHT_ENTRIES);
    localparam int TAG_W = PC_W - IB - 2;
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic             btbValid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btbTag    [BTB_ENTRIES];
    logic [PC_W-1:0]  btbTarget [BTB_ENTRIES];

    logic [IB-1:0]    btbIdxF, btbIdxE;
    logic [TAG_W-1:0] tagF, tagE;
    logic             hitF, bhtTakenF, mispredict;

    assign btbIdxF = PCF[IB+1:2];
    assign tagF    = PCF[PC_W-1:IB+2];
    assign btbIdxE = PCE[IB+1:2];
    assign tagE    = PCE[PC_W-1:IB+2];

    bp_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) uBht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdIdx   (PCF[HB+1:2]),
        .rdTaken (bhtTakenF),
        .wrEn    (UpdateE),
        .wrIdx   (PCE[HB+1:2]),
        .wrTaken (BrTakenE)
    );

    assign hitF        = btbValid[btbIdxF] && (btbTag[btbIdxF] == tagF);
    assign PredTakenF  = hitF && bhtTakenF;
    assign PredTargetF = hitF ? btbTarget[btbIdxF] : PCF + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btbValid[i] <= 1'b0;
        end else if (UpdateE && BrTakenE) begin
            btbValid[btbIdxE] <= 1'b1;
        end
    end

    // Tag and target are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (UpdateE && BrTakenE) begin
            btbTag[btbIdxE]    <= tagE;
            btbTarget[btbIdxE] <= BrTargetE;
        end
    end

    assign mispredict  = UpdateE &&
                         ((BrTakenE != PredTakenE) || (BrTakenE && (PredTargetE != BrTargetE)));
    assign MispredictE = mispredict;
    assign CorrectPCE  = BrTakenE ? BrTargetE : PCE + PC_STEP;

`ifdef BP_PERF_CNT_EN
    logic [31:0] branchCntQ, missCntQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branchCntQ <= '0;
            missCntQ   <= '0;
        end else begin
            if (UpdateE && (branchCntQ != 32'hFFFF_FFFF)) branchCntQ <= branchCntQ + 32'd1;
            if (mispredict && (missCntQ != 32'hFFFF_FFFF)) missCntQ <= missCntQ + 32'd1;
        end
    end

    assign BranchCnt = branchCntQ;
    assign MissCnt   = missCntQ;
`else
    assign BranchCnt = '0;
    assign MissCnt   = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed steps plus random
// traffic compared against a table-level reference model.
module tb_branch_predictor;

    localparam int BTB_N = 64;
    localparam int BHT_N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PCF = 32'h0;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateE = 1'b0;
    logic [31:0] PCE = 32'h0;
    logic        BrTakenE = 1'b0;
    logic [31:0] BrTargetE = 32'h0;
    logic        PredTakenE = 1'b0;
    logic [31:0] PredTargetE = 32'h0;
    logic        MispredictE;
    logic [31:0] CorrectPCE;
    logic [31:0] BranchCnt;
    logic [31:0] MissCnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          mCnt   [BHT_N];
    bit          mValid [BTB_N];
    logic [31:0] mTag   [BTB_N];
    logic [31:0] mTgt   [BTB_N];
    longint      mBranch;
    longint      mMiss;

    branch_predictor #(
        .BTB_ENTRIES (BTB_N),
        .BHT_ENTRIES (BHT_N),
        .PC_W        (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .UpdateE     (UpdateE),
        .PCE         (PCE),
        .BrTakenE    (BrTakenE),
        .BrTargetE   (BrTargetE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .MispredictE (MispredictE),
        .CorrectPCE  (CorrectPCE),
        .BranchCnt   (BranchCnt),
        .MissCnt     (MissCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int btbIdx(input logic [31:0] pc);
        return int'((pc / 4) % BTB_N);
    endfunction

    function automatic int bhtIdx(input logic [31:0] pc);
        return int'((pc / 4) % BHT_N);
    endfunction

    function automatic logic [31:0] btbTagOf(input logic [31:0] pc);
        return pc / (4 * BTB_N);
    endfunction

    function automatic bit mHit(input logic [31:0] pc);
        return mValid[btbIdx(pc)] && (mTag[btbIdx(pc)] == btbTagOf(pc));
    endfunction

    function automatic logic mPredTaken(input logic [31:0] pc);
        return mHit(pc) && (mCnt[bhtIdx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mPredTarget(input logic [31:0] pc);
        return mHit(pc) ? mTgt[btbIdx(pc)] : pc + 32'd4;
    endfunction

    function automatic logic mMispredict(input logic upd, input logic tk, input logic [31:0] tgt,
                                         input logic pTk, input logic [31:0] pTgt);
        return upd && ((tk != pTk) || (tk && (pTgt != tgt)));
    endfunction

    function automatic logic [31:0] expCount(input longint v);
`ifdef BP_PERF_CNT_EN
        return v[31:0];
`else
        return (v == 0) ? 32'h0 : 32'h0;
`endif
    endfunction

    task automatic modelReset();
        for (int i = 0; i < BHT_N; i++) mCnt[i] = 1;
        for (int i = 0; i < BTB_N; i++) begin
            mValid[i] = 1'b0;
            mTag[i]   = 32'h0;
            mTgt[i]   = 32'h0;
        end
        mBranch = 0;
        mMiss   = 0;
    endtask

    task automatic modelUpdate(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                               input logic pTk, input logic [31:0] pTgt);
        if (mMispredict(1'b1, tk, tgt, pTk, pTgt) && mMiss < 64'hFFFF_FFFF) mMiss++;
        if (mBranch < 64'hFFFF_FFFF) mBranch++;
        if (tk) begin
            if (mCnt[bhtIdx(pce)] < 3) mCnt[bhtIdx(pce)]++;
            mValid[btbIdx(pce)] = 1'b1;
            mTag[btbIdx(pce)]   = btbTagOf(pce);
            mTgt[btbIdx(pce)]   = tgt;
        end else begin
            if (mCnt[bhtIdx(pce)] > 0) mCnt[bhtIdx(pce)]--;
        end
    endtask

    // One cycle: drive, check combinational outputs against the model, clock, update model.
    task automatic step(input string tag, input logic [31:0] pcf, input logic upd,
                        input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                        input logic pTk, input logic [31:0] pTgt);
        PCF = pcf; UpdateE = upd; PCE = pce; BrTakenE = tk; BrTargetE = tgt;
        PredTakenE = pTk; PredTargetE = pTgt;
        #2;
        chk({tag, "_predTaken"},  {31'b0, PredTakenF},  {31'b0, mPredTaken(pcf)});
        chk({tag, "_predTarget"}, PredTargetF,          mPredTarget(pcf));
        chk({tag, "_mispredict"}, {31'b0, MispredictE}, {31'b0, mMispredict(upd, tk, tgt, pTk, pTgt)});
        chk({tag, "_correctPC"},  CorrectPCE,           tk ? tgt : pce + 32'd4);
        chk({tag, "_branchCnt"},  BranchCnt,            expCount(mBranch));
        chk({tag, "_missCnt"},    MissCnt,              expCount(mMiss));
        @(posedge clk);
        if (upd) modelUpdate(pce, tk, tgt, pTk, pTgt);
        #1;
        UpdateE = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [31:0] pcf, input logic expTk,
                        input logic [31:0] expTgt);
        PCF = pcf;
        #1;
        chk({tag, "_predTaken"},  {31'b0, PredTakenF}, {31'b0, expTk});
        chk({tag, "_predTarget"}, PredTargetF,         expTgt);
    endtask

    initial begin
        logic [31:0] pc, pcf, tgt, pTgt;
        logic tk, pTk, upd;

        modelReset();
        PCF = 32'h100;
        #12;
        peek("rst", 32'h100, 1'b0, 32'h104);
        chk("rst_branchCnt", BranchCnt, 32'h0);
        chk("rst_missCnt", MissCnt, 32'h0);
        chk("rst_mispredict", {31'b0, MispredictE}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        step("train1", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        peek("afterTrain", 32'h100, 1'b1, 32'h80);

        for (int i = 0; i < 4; i++) step("nt", 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        peek("sat00", 32'h100, 1'b0, 32'h80);
        for (int i = 0; i < 2; i++) step("tk", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        peek("back10", 32'h100, 1'b1, 32'h80);

        step("alias", 32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        peek("aliasMiss", 32'h100, 1'b0, 32'h104);

        step("mpTgt", 32'h0, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        step("mpDir", 32'h0, 1'b1, 32'h100, 1'b0, 32'h90, 1'b1, 32'h80);
        step("noUpd", 32'h0, 1'b0, 32'h100, 1'b1, 32'h90, 1'b0, 32'h80);
        step("wrap", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            pc   = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            pcf  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            tk   = 1'($urandom_range(0, 1));
            upd  = ($urandom_range(0, 3) != 0);
            tgt  = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 1) == 1) begin
                pTk  = mPredTaken(pc);
                pTgt = mPredTarget(pc);
            end else begin
                pTk  = 1'($urandom_range(0, 1));
                pTgt = ($urandom_range(0, 1) == 1) ? tgt : 32'($urandom);
            end
            step("rnd", pcf, upd, pc, tk, tgt, pTk, pTgt);
        end

        step("pre", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        step("pre", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        peek("preRst", 32'h100, 1'b1, 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        peek("midRst", 32'h100, 1'b0, 32'h104);
        chk("midRst_branchCnt", BranchCnt, 32'h0);
        chk("midRst_missCnt", MissCnt, 32'h0);
        chk("midRst_mispredict", {31'b0, MispredictE}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        step("cnt1", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        step("cnt2", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        step("cnt3", 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        #1;
`ifdef BP_PERF_CNT_EN
        chk("perf_branch3", BranchCnt, 32'd3);
        chk("perf_miss1", MissCnt, 32'd1);
`else
        chk("perf_branchOff", BranchCnt, 32'd0);
        chk("perf_missOff", MissCnt, 32'd0);
`endif
        rst_n = 1'b0;
        #1;
        modelReset();
        chk("perfRst_branch", BranchCnt, 32'h0);
        chk("perfRst_miss", MissCnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step("post", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the five-stage RV32I pipeline. It combines a direct-mapped branch target buffer (BTB) with a table of 2-bit saturating counters (BHT). It sits beside the next-PC generator: the fetch stage looks up the current PC in the same cycle, and the execute stage trains the predictor on resolved conditional branches and reports whether the prediction was wrong.

## Interface
Parameters:
- `BTB_ENTRIES`, default 64: BTB depth; a power of 2, ≥ 4.
- `BHT_ENTRIES`, default 256: BHT depth; a power of 2, ≥ 4.
- `PC_W`, default 32: width of PC and target.

Ports (clock and reset first):
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PCF` in PC_W: fetch-stage PC.
- `PredTakenF` out 1: predicted taken for `PCF`.
- `PredTargetF` out PC_W: predicted target, valid when `PredTakenF`.
- `UpdateE` in 1: conditional branch resolved in EX. The caller qualifies it with ~StallE and a not-flushed condition.
- `PCE` in PC_W: PC of the resolving branch.
- `BrTakenE` in 1: actual outcome.
- `BrTargetE` in PC_W: actual target.
- `PredTakenE` in 1: prediction piped from F to E.
- `PredTargetE` in PC_W: prediction piped from F to E.
- `MispredictE` out 1: the pipeline must flush IF/ID and redirect.
- `CorrectPCE` out PC_W: the redirect PC.
- `BranchCnt` out 32: resolved-branch count.
- `MissCnt` out 32: mispredict count.

## Operation
- Index fields:
  - BTB index IB = log2(BTB_ENTRIES). The BTB index is `PC[IB+1:2]`; the tag is `PC[PC_W-1:IB+2]`.
  - BHT index = `PC[log2(BHT_ENTRIES)+1:2]`, with independent aliasing.
- BTB entry contents: valid, tag, target.
- BHT counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup (combinational):
  - hit = valid && tag match.
  - `PredTakenF` = hit && BHT[idx][1].
  - `PredTargetF` = BTB target on a hit, otherwise `PCF+4`.
- Update on an edge with `UpdateE`=1:
  - BHT: increment on taken, decrement on not-taken; saturate at 11 and 00.
  - BTB, taken branch: write valid=1, the tag, and `BrTargetE`. This overwrites any aliasing entry.
  - BTB, not-taken branch: leave the entry untouched.
- Mispredict:
  - `MispredictE` = UpdateE && (BrTakenE≠PredTakenE || (BrTakenE && PredTargetE≠BrTargetE)).
  - `MispredictE` is 0 whenever UpdateE=0.
- Redirect: `CorrectPCE` = BrTakenE ? BrTargetE : PCE+4. It is computed regardless of UpdateE.
- Scope: JAL and JALR are outside this block. UpdateE must be 0 for them.

## Timing
- Lookup has zero-cycle latency, from `PCF` to `PredTakenF`/`PredTargetF`.
- An update is visible to lookups from the cycle after the `UpdateE` edge.
- Simultaneous lookup and update at the same index: the lookup returns the pre-update value (no bypass).
- Reset (asynchronous, also mid-operation):
  - All BTB valid bits clear; tags and targets are don't-care.
  - All BHT counters reset to 01.
  - Counters reset to 0.
  - Outputs settle to `PredTakenF`=0, `PredTargetF`=PCF+4 and `MispredictE`=0.
- PC+4 arithmetic is modulo 2^PC_W; wrap-around is allowed.

## Configuration
- `BP_PERF_CNT_EN` defined:
  - `BranchCnt` increments on every edge with UpdateE=1.
  - `MissCnt` increments on every edge with MispredictE=1.
  - Both saturate at 32'hFFFFFFFF.
- `BP_PERF_CNT_EN` undefined: no counter registers; both ports are tied to 0.

## Structure
- Shared package `bp_pkg`:
  - counter encoding constants `BP_SNT`/`BP_WNT`/`BP_WT`/`BP_ST`;
  - the reset value `BP_CNT_RST`=`BP_WNT`;
  - the function computing next counter state.
- One sub-module, `bp_bht`: the BHT array with its read port, write port and saturation logic.
- BTB and mispredict logic stay in the top module.

## Test plan
- Reset, then lookup `PCF`=0x100 → PredTakenF=0, PredTargetF=0x104; all counters 0.
- Taken branch at 0x100 to target 0x80, updated once → next-cycle lookup 0x100 gives PredTakenF=1 (BHT 01→10), PredTargetF=0x80.
- Four not-taken updates at 0x100 → counter 00, PredTakenF=0. Two taken updates → 10, PredTakenF=1.
- Alias: with BTB_ENTRIES=64, take a taken branch at 0x100 then at 0x200 (same index, different tag) → lookup 0x100 misses, PredTargetF=0x104.
- Mispredict: PredTakenE=1, PredTargetE=0x80, BrTakenE=1, BrTargetE=0x90 → MispredictE=1, CorrectPCE=0x90. Same with BrTakenE=0, PCE=0x100 → CorrectPCE=0x104.
- Assert rst_n low mid-stream after training → PredTakenF=0 immediately. With `BP_PERF_CNT_EN`: 3 updates including 1 miss → BranchCnt=3, MissCnt=1 before reset, 0 after.
